// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction ROM port, redirect/stall controls from later stages and the IF/ID register outputs.
interface if_stage_if #(
  parameter int unsigned COUNT_W = 32
);
  logic [31:0]        imem_addr;
  logic [31:0]        imem_rdata;
  logic               stall;
  logic               redirect_en;
  logic [31:0]        redirect_pc;
  logic [31:0]        ifid_instr;
  logic [31:0]        ifid_pc4;
  logic               ifid_valid;
  logic               halted;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall,
    input  redirect_en,
    input  redirect_pc,
    output ifid_instr,
    output ifid_pc4,
    output ifid_valid,
    output halted,
    output instr_count
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall,
    output redirect_en,
    output redirect_pc,
    input  ifid_instr,
    input  ifid_pc4,
    input  ifid_valid,
    input  halted,
    input  instr_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch + IF/ID register with redirect, stall, STOP drain and halt.
// Define FETCH_PERF_CNT_EN to implement the instr_count counter; otherwise instr_count reads 0.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned STOP_DRAIN = 4,
  parameter int unsigned COUNT_W    = 32
) (
  input logic        clk,
  input logic        reset,
  if_stage_if.master bus
);
  // state | meaning:  RUN = fetching, DRAIN = STOP seen, emitting bubbles, HALTED = frozen until reset
  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  localparam int unsigned CNT_W = (STOP_DRAIN > 1) ? $clog2(STOP_DRAIN) : 1;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        pc_plus4;
  logic [31:0]        redirect_aligned;
  logic               is_stop;

  assign pc_plus4         = pc_q + 32'd4;
  assign redirect_aligned = bus.redirect_pc & 32'hFFFF_FFFC;
  assign is_stop          = (bus.imem_rdata[31:26] == 6'd63);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_RUN: begin
        if (bus.redirect_en) begin
          pc_d    = redirect_aligned;
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (is_stop) begin
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          state_d = S_DRAIN;
          cnt_d   = CNT_W'(STOP_DRAIN - 1);
        end else begin
          pc_d    = pc_plus4;
          instr_d = bus.imem_rdata;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
        end
      end
      S_DRAIN: begin
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
        // A redirect here means the STOP itself was on a mispredicted path.
        if (bus.redirect_en) begin
          pc_d    = redirect_aligned;
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HALTED: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  assign bus.imem_addr  = pc_q;
  assign bus.ifid_instr = instr_q;
  assign bus.ifid_pc4   = pc4_q;
  assign bus.ifid_valid = valid_q;
  assign bus.halted     = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [COUNT_W-1:0] count_q, count_d;
  logic               count_en;

  assign count_en = (state_q == S_RUN) && !bus.redirect_en && !bus.stall && !is_stop;
  assign count_d  = count_en ? (count_q + COUNT_W'(1)) : count_q;

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign bus.instr_count = count_q;
`else
  assign bus.instr_count = '0;
`endif
endmodule
